// File: rtl/coherence_bus_ctrl.sv
// Two-level bus arbiter for CPUS cores sharing one RAM port: data writebacks,
// coherent reads/upgrades with a snoop phase, and instruction fetches.
module coherence_bus_ctrl #(
    parameter int CPUS = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0][31:0]  iaddr,
    input  logic [CPUS-1:0][31:0]  daddr,
    input  logic [CPUS-1:0][31:0]  dstore,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [CPUS-1:0]        cctrans,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0][31:0]  iload,
    output logic [CPUS-1:0][31:0]  dload,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS-1:0][31:0]  ccsnoopaddr
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [IW-1:0] LAST_CPU = IW'(CPUS - 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DATA_WR = 3'd1;
    localparam logic [2:0] SNOOP   = 3'd2;
    localparam logic [2:0] SUPPLY  = 3'd3;
    localparam logic [2:0] RAM_RD  = 3'd4;
    localparam logic [2:0] IFETCH  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] o_idx;
    logic [CPUS-1:0] coh_req;
    logic          ram_acc;

    function automatic logic [IW-1:0] next_cpu(input logic [IW-1:0] idx);
        return (idx == LAST_CPU) ? '0 : idx + 1'b1;
    endfunction

    // Round-robin: search starts at the cpu after the last one served.
    function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] idx;
        logic          found;
        logic [IW-1:0] pick;
        idx   = last;
        found = 1'b0;
        pick  = last;
        for (int i = 0; i < CPUS; i++) begin
            idx = next_cpu(idx);
            if (req[idx] && !found) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign coh_req = dREN | (ccwrite & cctrans);
    assign o_idx   = next_cpu(g_q);
    assign ram_acc = (ramstate == RAM_ACCESS);

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        last_d      = last_q;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ramaddr     = '0;
        ramstore    = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;

        case (state_q)
            IDLE: begin
                if (|dWEN) begin
                    g_d     = rr_pick(dWEN, last_q);
                    state_d = DATA_WR;
                end else if (|coh_req) begin
                    g_d     = rr_pick(coh_req, last_q);
                    state_d = SNOOP;
                end else if (|iREN) begin
                    g_d     = rr_pick(iREN, last_q);
                    state_d = IFETCH;
                end
            end
            DATA_WR: begin
                if (ram_acc) begin
                    ramWEN     = 1'b1;
                    ramaddr    = daddr[g_q];
                    ramstore   = dstore[g_q];
                    dwait[g_q] = 1'b0;
                end
                if (!dWEN[g_q]) state_d = IDLE;
            end
            SNOOP: begin
                ccwait[o_idx]      = 1'b1;
                ccsnoopaddr[o_idx] = daddr[g_q];
                ccinv[o_idx]       = ccwrite[g_q];
                if (dWEN[o_idx]) begin
                    state_d = SUPPLY;
                end else if (cctrans[o_idx]) begin
                    if (dREN[g_q]) begin
                        state_d = RAM_RD;
                    end else begin
                        // upgrade: the other cache invalidated, no data to move
                        dwait[g_q] = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            SUPPLY: begin
                ccwait[o_idx]      = 1'b1;
                ccsnoopaddr[o_idx] = daddr[g_q];
                ramWEN             = 1'b1;
                ramaddr            = daddr[o_idx];
                ramstore           = dstore[o_idx];
                dload[g_q]         = dstore[o_idx];
                if (ram_acc) begin
                    dwait[g_q]   = 1'b0;
                    dwait[o_idx] = 1'b0;
                end
                if (!dWEN[o_idx]) state_d = IDLE;
            end
            RAM_RD: begin
                ccwait[o_idx]      = 1'b1;
                ccsnoopaddr[o_idx] = daddr[g_q];
                ramREN             = 1'b1;
                ramaddr            = daddr[g_q];
                dload[g_q]         = ramload;
                if (ram_acc) dwait[g_q] = 1'b0;
                if (!dREN[g_q]) state_d = IDLE;
            end
            IFETCH: begin
                ramREN     = 1'b1;
                ramaddr    = iaddr[g_q];
                iload[g_q] = ramload;
                if (ram_acc) begin
                    iwait[g_q] = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && state_d == IDLE) last_d = g_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= LAST_CPU;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: arbitration, snoop/supply/upgrade
// paths, reset mid-transaction and RAM error stalls.
module tb_coherence_bus_ctrl;

    localparam logic [1:0] R_FREE   = 2'd0;
    localparam logic [1:0] R_BUSY   = 2'd1;
    localparam logic [1:0] R_ACCESS = 2'd2;
    localparam logic [1:0] R_ERROR  = 2'd3;

    logic             CLK;
    logic             RST;
    logic [1:0]       iREN, dREN, dWEN, ccwrite, cctrans;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic [31:0]      ramaddr, ramstore;
    logic             ramREN, ramWEN;

    typedef struct {
        string       tag;
        int          cpu;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    coherence_bus_ctrl #(.CPUS(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .ccwrite(ccwrite), .cctrans(cctrans),
        .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_iwait"}, 32'(iwait), 32'(2'b11));
        chk({tag, "_dwait"}, 32'(dwait), 32'(2'b11));
        chk({tag, "_ram_en"}, 32'({ramREN, ramWEN}), 32'(2'b00));
        chk({tag, "_ccwait"}, 32'(ccwait), 32'(2'b00));
        chk({tag, "_ramaddr"}, ramaddr, 32'h0);
    endtask

    // Pops the next expected fetch when the controller raises ramREN, then
    // holds the RAM in `filler` for `lat` cycles before answering.
    task automatic serve_ifetch(input int lat, input logic [1:0] filler);
        exp_t       e;
        int         n;
        logic [1:0] wmask;
        n = 0;
        while (ramREN !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        chk({e.tag, "_ren"}, 32'(ramREN), 32'h1);
        chk({e.tag, "_addr"}, ramaddr, e.addr);
        for (int k = 0; k < lat; k++) begin
            ramstate = filler;
            #1;
            chk({e.tag, "_stall_iwait"}, 32'(iwait), 32'(2'b11));
            chk({e.tag, "_stall_ren"}, 32'(ramREN), 32'h1);
            tick();
        end
        ramstate = R_ACCESS;
        ramload  = e.data;
        #1;
        wmask = 2'b11;
        wmask[e.cpu] = 1'b0;
        chk({e.tag, "_iwait"}, 32'(iwait), 32'(wmask));
        chk({e.tag, "_iload"}, iload[e.cpu], e.data);
        tick();
        ramstate = R_FREE;
        ramload  = '0;
        #1;
        chk({e.tag, "_done_iwait"}, 32'(iwait), 32'(2'b11));
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = R_FREE;
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk_idle("reset");

        // Both cpus fetch: cpu0 first, then cpu1, then cpu0 again.
        iREN = 2'b11;
        iaddr[0] = 32'h40;
        iaddr[1] = 32'h80;
        e = '{tag: "if0", cpu: 0, addr: 32'h40, data: 32'h1111_0000};
        sb.push_back(e);
        serve_ifetch(2, R_BUSY);
        e = '{tag: "if1", cpu: 1, addr: 32'h80, data: 32'h2222_0000};
        sb.push_back(e);
        serve_ifetch(2, R_FREE);
        e = '{tag: "if0b", cpu: 0, addr: 32'h40, data: 32'h3333_0000};
        sb.push_back(e);
        serve_ifetch(0, R_BUSY);
        iREN = 2'b00;

        // Writeback from cpu0 beats cpu1's read issued in the same cycle.
        dWEN = 2'b01; daddr[0] = 32'h200; dstore[0] = 32'hA5A5_A5A5;
        dREN = 2'b10; daddr[1] = 32'h300;
        tick();
        chk("wr_free_dwait", 32'(dwait), 32'(2'b11));
        chk("wr_no_snoop", 32'(ccwait), 32'(2'b00));
        ramstate = R_ACCESS;
        #1;
        chk("wr_wen", 32'(ramWEN), 32'h1);
        chk("wr_ren", 32'(ramREN), 32'h0);
        chk("wr_addr", ramaddr, 32'h200);
        chk("wr_store", ramstore, 32'hA5A5_A5A5);
        chk("wr_dwait", 32'(dwait), 32'(2'b10));
        tick();
        ramstate = R_BUSY;
        dWEN = 2'b00;
        #1;
        chk("wr_busy_dwait", 32'(dwait), 32'(2'b11));
        tick();
        ramstate = R_FREE;
        #1;
        chk_idle("wr_done");

        // cpu1 read now granted: snoop cpu0, which answers with cctrans only.
        e = '{tag: "rd1", cpu: 1, addr: 32'h300, data: 32'h1234_5678};
        sb.push_back(e);
        tick();
        chk("rd_snoop_ccwait", 32'(ccwait), 32'(2'b01));
        chk("rd_snoop_addr", ccsnoopaddr[0], 32'h300);
        chk("rd_snoop_inv", 32'(ccinv), 32'(2'b00));
        chk("rd_snoop_dwait", 32'(dwait), 32'(2'b11));
        cctrans = 2'b01;
        tick();
        e = sb.pop_front();
        chk("rd_ren", 32'(ramREN), 32'h1);
        chk("rd_addr", ramaddr, e.addr);
        chk("rd_ccwait", 32'(ccwait), 32'(2'b01));
        chk("rd_snoopaddr", ccsnoopaddr[0], e.addr);
        chk("rd_wait_dwait", 32'(dwait), 32'(2'b11));
        ramstate = R_ACCESS;
        ramload  = e.data;
        #1;
        chk("rd_dwait", 32'(dwait), 32'(2'b01));
        chk("rd_dload", dload[1], e.data);
        tick();
        ramstate = R_FREE;
        dREN = 2'b00;
        cctrans = 2'b00;
        tick();
        chk_idle("rd_done");

        // cpu0 coherent read supplied cache-to-cache by cpu1.
        dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h100;
        tick();
        chk("sup_snoop_ccwait", 32'(ccwait), 32'(2'b10));
        chk("sup_snoop_addr", ccsnoopaddr[1], 32'h100);
        chk("sup_snoop_addr0", ccsnoopaddr[0], 32'h0);
        chk("sup_snoop_inv", 32'(ccinv), 32'(2'b00));
        chk("sup_snoop_ram", 32'({ramREN, ramWEN}), 32'(2'b00));
        tick();
        chk("sup_snoop_hold", 32'(ccwait), 32'(2'b10));
        dWEN = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'hDEAD_BEEF;
        e = '{tag: "sup", cpu: 0, addr: 32'h100, data: 32'hDEAD_BEEF};
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        chk("sup_wen", 32'(ramWEN), 32'h1);
        chk("sup_ren", 32'(ramREN), 32'h0);
        chk("sup_addr", ramaddr, e.addr);
        chk("sup_store", ramstore, e.data);
        chk("sup_dload", dload[0], e.data);
        chk("sup_wait_dwait", 32'(dwait), 32'(2'b11));
        chk("sup_ccwait", 32'(ccwait), 32'(2'b10));
        ramstate = R_ACCESS;
        #1;
        chk("sup_dwait", 32'(dwait), 32'(2'b00));
        tick();
        ramstate = R_FREE;
        dWEN = 2'b00; dREN = 2'b00; cctrans = 2'b00;
        tick();
        chk_idle("sup_done");

        // cpu0 upgrade: invalidate cpu1, one-cycle release, no RAM traffic.
        ccwrite = 2'b01; cctrans = 2'b01; daddr[0] = 32'h140;
        tick();
        chk("upg_inv", 32'(ccinv), 32'(2'b10));
        chk("upg_snoop_addr", ccsnoopaddr[1], 32'h140);
        chk("upg_wait_dwait", 32'(dwait), 32'(2'b11));
        cctrans = 2'b11;
        #1;
        chk("upg_dwait", 32'(dwait), 32'(2'b10));
        chk("upg_ram", 32'({ramREN, ramWEN}), 32'(2'b00));
        tick();
        ccwrite = 2'b00; cctrans = 2'b00;
        #1;
        chk_idle("upg_done");

        // Coherent beats fetch; reset lands in RAM_RD.
        iREN = 2'b01; iaddr[0] = 32'h44;
        dREN = 2'b10; daddr[1] = 32'h180;
        tick();
        chk("prio_ccwait", 32'(ccwait), 32'(2'b01));
        chk("prio_ren", 32'(ramREN), 32'h0);
        cctrans = 2'b01;
        tick();
        chk("rst_pre_ren", 32'(ramREN), 32'h1);
        chk("rst_pre_addr", ramaddr, 32'h180);
        RST = 1'b1;
        tick();
        chk_idle("rst_mid");
        dREN = 2'b00; cctrans = 2'b00; iREN = 2'b00;
        tick();
        chk_idle("rst_hold");
        RST = 1'b0;

        // After reset cpu0 wins the fetch tie again; RAM reports ERROR for a while.
        iREN = 2'b11;
        e = '{tag: "err0", cpu: 0, addr: 32'h44, data: 32'hCAFE_0001};
        sb.push_back(e);
        serve_ifetch(10, R_ERROR);
        iREN = 2'b10;
        e = '{tag: "err1", cpu: 1, addr: 32'h80, data: 32'hCAFE_0002};
        sb.push_back(e);
        serve_ifetch(1, R_ERROR);
        iREN = 2'b00;
        tick();
        chk_idle("final");
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
